// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between display fetch (reads, hard
// priority) and host writes (started only during vertical blanking). A watchdog
// aborts any access the memory never answers so neither requester hangs.
// Optional build macro VRAM_ARB_ACTIVE_WRITE_EN lets host writes start outside
// blanking whenever no fetch is pending.
module vram_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic        fetch_req,
    input  logic [13:1] fetch_addr,
    output logic [15:0] fetch_data,
    output logic        fetch_done,
    input  logic        host_cs,
    input  logic [13:1] host_addr,
    input  logic [15:0] host_data,
    output logic        host_done,
    output logic        host_write_avail,
    output logic        vram_cs,
    output logic        vram_we,
    output logic [13:1] vram_addr,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata,
    input  logic        vram_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StHack} state_e;

    // Counter value on the last cycle before the access is abandoned.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       write_start;
    logic       avail_next;

    assign tmo_hit = (tmo_cnt == TmoLast);

`ifdef VRAM_ARB_ACTIVE_WRITE_EN
    // Host writes may start at any time; only a pending fetch blocks them.
    always_comb begin
        write_start = host_cs;
        avail_next  = (state == StIdle) & ~host_cs & ~fetch_req;
    end
`else
    // Host writes may only start while the display is blanked.
    always_comb begin
        write_start = host_cs & vblank;
        avail_next  = vblank & (state == StIdle) & ~host_cs;
    end
`endif

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state            <= StIdle;
            tmo_cnt          <= 8'd0;
            vram_cs          <= 1'b0;
            vram_we          <= 1'b0;
            vram_addr        <= '0;
            vram_wdata       <= 16'h0000;
            fetch_data       <= 16'h0000;
            fetch_done       <= 1'b0;
            host_done        <= 1'b0;
            host_write_avail <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            fetch_done       <= 1'b0;
            host_write_avail <= avail_next;
            case (state)
                StIdle: begin
                    if (fetch_req) begin
                        state     <= StRead;
                        tmo_cnt   <= 8'd0;
                        vram_cs   <= 1'b1;
                        vram_we   <= 1'b0;
                        vram_addr <= fetch_addr;
                    end else if (write_start) begin
                        state      <= StWrite;
                        tmo_cnt    <= 8'd0;
                        vram_cs    <= 1'b1;
                        vram_we    <= 1'b1;
                        vram_addr  <= host_addr;
                        vram_wdata <= host_data;
                    end
                end
                StRead: begin
                    if (vram_done) begin
                        fetch_data <= vram_rdata;
                        fetch_done <= 1'b1;
                        vram_cs    <= 1'b0;
                        state      <= StIdle;
                    end else if (tmo_hit) begin
                        // Abandon the read but still answer so the fetch path moves on.
                        fetch_data  <= 16'h0000;
                        fetch_done  <= 1'b1;
                        vram_cs     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                StWrite: begin
                    // vblank is not rechecked here: a started write always finishes.
                    if (vram_done) begin
                        vram_cs   <= 1'b0;
                        host_done <= 1'b1;
                        state     <= StHack;
                    end else if (tmo_hit) begin
                        vram_cs     <= 1'b0;
                        host_done   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= StHack;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                StHack: begin
                    if (!host_cs) begin
                        host_done <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single asynchronous VRAM port between two requesters: the display fetch path (reads, hard priority) and the host write path (writes, permitted only during vertical blanking). It sits between the graphics core top level and the board-level memory adapter. Host writes issued during active display stall via a held `host_done` until blanking opens. A timeout watchdog flags a memory controller that never answers.

## Interface
- `TIMEOUT`, default 15: pixel clocks to wait for `vram_done` before aborting an access (1..255).
- `pixel_clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `vblank` in 1: high during vertical blanking (from timing generator, pixel_clk domain).
- `fetch_req` in 1: display fetch requests a read; held until `fetch_done`.
- `fetch_addr` in 13 [13:1]: word address to read.
- `fetch_data` out 16: read data, valid in the `fetch_done` cycle, held until next read completes.
- `fetch_done` out 1: one-cycle pulse, read complete.
- `host_cs` in 1: host write request; held until `host_done` seen.
- `host_addr` in 13 [13:1]: write word address.
- `host_data` in 16: write data.
- `host_done` out 1: high from write completion until `host_cs` deasserts.
- `host_write_avail` out 1: registered; a write issued now completes without stalling.
- `vram_cs` out 1: memory chip select.
- `vram_we` out 1: 1 = write, 0 = read; valid while `vram_cs`.
- `vram_addr` out 13 [13:1]: memory address.
- `vram_wdata` out 16: write data; board adapter drives the bidirectional bus when `vram_cs & vram_we`.
- `vram_rdata` in 16: read data from adapter.
- `vram_done` in 1: memory reports read data ready / write complete.
- `timeout_err` out 1: sticky; set when an access times out, cleared only by `reset`.

## Operation
- States: IDLE, READ, WRITE, HACK.
- IDLE: if `fetch_req` → READ (latch `fetch_addr`, `vram_cs`=1, `vram_we`=0). Else if `host_cs` & `vblank` → WRITE (latch `host_addr`/`host_data`, `vram_cs`=1, `vram_we`=1). Fetch always wins a same-cycle conflict.
- READ: on `vram_done` → capture `vram_rdata` into `fetch_data`, pulse `fetch_done`, drop `vram_cs`, → IDLE.
- WRITE: on `vram_done` → drop `vram_cs`, set `host_done`, → HACK.
- HACK: hold `host_done` until `host_cs` low, then clear it, → IDLE. Fetch requests wait during HACK.
- Timeout: counter (8 bit) cleared on entering READ/WRITE, increments each cycle without `vram_done`; reaching `TIMEOUT` sets `timeout_err`, drops `vram_cs`, completes the transaction anyway (READ: `fetch_done` pulse, `fetch_data`=16'h0000; WRITE: → HACK) so neither requester hangs.
- `vblank` falling while in WRITE: write finishes normally; gate applies only to starting.
- `host_write_avail` ← `vblank` & (state = IDLE) & ~`host_cs`, registered each cycle.
- Addresses wrap naturally within 13 bits; no range checks.

## Timing
- Reset values: `vram_cs`=0, `vram_we`=0, `vram_addr`=0, `vram_wdata`=0, `fetch_data`=0, `fetch_done`=0, `host_done`=0, `host_write_avail`=0, `timeout_err`=0, state IDLE.
- All outputs registered. `vram_cs` asserts 1 cycle after request sampled in IDLE.
- Read latency with `vram_done` returned in the first cycle of `vram_cs`: request→`fetch_done` = 2 cycles. Back-to-back reads: one every 2 cycles.
- Write: `host_done` rises 1 cycle after `vram_done`; IDLE 1 cycle after `host_cs` falls.
- `reset` mid-access: `vram_cs` drops next edge, pending data discarded, no `done` emitted.

## Configuration
- `VRAM_ARB_ACTIVE_WRITE_EN`: when defined, IDLE also starts a host write outside blanking whenever `fetch_req` is low (fetch priority unchanged), and `host_write_avail` ← (state = IDLE) & ~`host_cs` & ~`fetch_req`. When undefined, writes start only with `vblank` high, as above.

## Test plan
- Read: `fetch_req`, addr 13'h0123, memory returns 16'hBEEF 1 cycle after `vram_cs` → `vram_we`=0, `vram_addr`=13'h0123, `fetch_done` pulse with `fetch_data`=16'hBEEF, 3 cycles after request.
- Stall: `host_cs` at addr 13'h0400 data 16'h1234 with `vblank`=0 for 100 cycles → no `vram_cs`, `host_done`=0; `vblank` rises → write issued, `host_done` held until `host_cs` drops.
- Conflict: `fetch_req` and `host_cs` same cycle in vblank → read first, then write; `host_write_avail`=0 throughout.
- Timeout: `vram_done` never asserted, `TIMEOUT`=15 → `vram_cs` drops 15 cycles in, `fetch_done` with 16'h0000, `timeout_err`=1 until reset.
- Reset mid-WRITE → next edge all outputs at reset values; subsequent read completes normally.
- With `VRAM_ARB_ACTIVE_WRITE_EN`: `vblank`=0, `fetch_req`=0, `host_cs` → write starts next cycle.
